shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Sequencer for the 8-bit bidirectional shift register in the ALU shift path.
//  On a start request it parallel-loads an operand, then applies AMOUNT single-bit
//  shifts in the requested direction, then pulses DONE with the result.
//  The register has no hold mode (load=0 always shifts). This block creates hold
//  by reloading the register's own output.
// PARAMETERS
//  WIDTH   8  datapath width; must match the shift register
//  AMT_W   3  width of shift amount; max amount = 2**AMT_W-1
// PORTS
//  clk      in   1      system clock, rising edge
//  rst      in   1      asynchronous reset, active-high
//  start    in   1      request; sampled only in IDLE
//  dir      in   1      0 = toward LSB (arith right, q[7] kept); 1 = toward MSB (q[0] kept)
//  amount   in   AMT_W  number of single-bit shifts
//  operand  in   WIDTH  value to load
//  sr_q     in   WIDTH  shift register output o
//  sr_load  out  1      to shift register load
//  sr_dr    out  1      to shift register dr
//  sr_in    out  WIDTH  to shift register IN
//  busy     out  1      high in LOAD and SHIFT
//  done     out  1      one-cycle pulse; result valid this cycle
//  result   out  WIDTH  equals sr_q; qualified by done
// BEHAVIOUR
//  States: IDLE, LOAD, SHIFT, DONE. Encoding is binary.
//  - IDLE: sr_load=1, sr_in=sr_q (hold), sr_dr=0.
//    - start=1: latch dir and amount, go to LOAD.
//  - LOAD (1 cycle): sr_load=1, sr_in=operand.
//    - amount=0: go to DONE.
//    - otherwise: cnt<=amount, go to SHIFT.
//  - SHIFT: sr_load=0, sr_dr=dir_latched, cnt decrements each cycle.
//    - cnt==1: go to DONE, after exactly amount shift edges.
//  - DONE (1 cycle): hold as in IDLE, done=1, result=sr_q. Then go to IDLE.
//  Latency: start edge -> done high after 1+amount+1 edges (done asserted in the cycle after the last shift).
//  start while busy or during DONE is ignored, not queued.
//  operand is sampled at the LOAD edge, not the start edge. The requester holds it stable until busy=1.
//  dir and amount are latched at the start edge; later changes have no effect.
//  Reset values (async, immediate): state=IDLE, cnt=0, dir_latched=0, busy=0, done=0, sr_load=1, sr_dr=0.
//  Reset mid-operation aborts: no done pulse. The shift register shares rst, so sr_q=0.
//  The next start after reset release behaves normally.
//  No zero-fill shifts. Fill behaviour is defined by the datapath (edge bit replicated).
//  All outputs except cnt/state regs are combinational decodes of state; no output glitch is relied on.
// STRUCTURE
//  Shared include alu_defs.vh holds:
//   - state localparams S_IDLE/S_LOAD/S_SHIFT/S_DONE
//   - DIR_RIGHT=0 / DIR_LEFT=1
//  One sub-module: shift_amt_counter.
//   - loadable down-counter, width AMT_W, with load/dec inputs and a zero flag
//  Top holds the FSM and output muxing.
//  Testbench instantiates this block wired to the real shift register (sr_q <- o).
// TESTING
//  1 operand=8'hB4, dir=1, amount=3
//    -> sr_q 68, D0, A0 on successive shift edges
//    -> done one cycle later with result=8'hA0
//    -> busy high for 4 cycles
//  2 operand=8'h96, dir=0, amount=2
//    -> sr_q CB, E5
//    -> done with result=8'hE5 (sign kept)
//  3 operand=8'h5A, amount=0
//    -> LOAD then DONE
//    -> done 2 edges after start, result=8'h5A
//    -> sr_load never 0
//  4 operand=8'h01, dir=1, amount=7
//    -> 03,07,...,FF
//    -> result=8'hFF at done
//    -> sr_q then holds FF for 5 idle cycles
//  5 start pulsed again mid-SHIFT with a different operand
//    -> ignored
//    -> original result delivered
//    -> exactly one done pulse
//  6 rst asserted during SHIFT of test 1
//    -> immediately busy=0, done=0, sr_load=1, sr_q=0
//    -> no done pulse
//    -> repeat test 1 after release gives 8'hA0

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the ALU shift-path sequencer: FSM states and
// direction codes as seen by the 8-bit bidirectional shift register.
package shift_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // dr input of the shift register: 0 = toward LSB (MSB replicated),
   // 1 = toward MSB (LSB replicated).
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_amt_counter.sv
// Loadable down-counter tracking the remaining single-bit shifts.
module shift_amt_counter #(
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [AMT_W-1:0] d,
   output logic [AMT_W-1:0] cnt,
   output logic             zero
);

   // load has priority over decrement; decrement saturates at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= d;
      else if (dec && (cnt != '0))
         cnt <= cnt - AMT_W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for the ALU shift-path register: loads an operand, applies a
// latched number of single-bit shifts in a latched direction, then pulses
// done. The register always shifts when load=0, so holding is done by
// reloading its own output.
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dir,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] operand,
   input  logic [WIDTH-1:0] sr_q,
   output logic             sr_load,
   output logic             sr_dr,
   output logic [WIDTH-1:0] sr_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_t           state, next;
   logic             dir_q;
   logic [AMT_W-1:0] amt_q;
   logic [AMT_W-1:0] cnt;
   logic             cnt_zero;
   logic             cnt_load;
   logic             cnt_dec;
   logic             latch;

   shift_amt_counter #(.AMT_W(AMT_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .dec  (cnt_dec),
      .d    (amt_q),
      .cnt  (cnt),
      .zero (cnt_zero)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= next;
   end

   // capture dir/amount on the accepted start edge; later input changes are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_q <= DIR_RIGHT;
         amt_q <= '0;
      end else if (latch) begin
         dir_q <= dir;
         amt_q <= amount;
      end
   end

   // next-state and output decode; default is "hold" (reload own output)
   always_comb begin
      next     = state;
      sr_load  = 1'b1;
      sr_dr    = DIR_RIGHT;
      sr_in    = sr_q;
      busy     = 1'b0;
      done     = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      latch    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               latch = 1'b1;
               next  = S_LOAD;
            end
         end
         S_LOAD: begin
            busy  = 1'b1;
            sr_in = operand;
            if (amt_q == '0) begin
               next = S_DONE;
            end else begin
               cnt_load = 1'b1;
               next     = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy    = 1'b1;
            sr_load = 1'b0;
            sr_dr   = dir_q;
            cnt_dec = 1'b1;
            // zero check only guards against a stuck count; normal exit is cnt==1
            if ((cnt == AMT_W'(1)) || cnt_zero)
               next = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            next = S_IDLE;
         end
         default: next = S_IDLE;
      endcase
   end

   assign result = sr_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench: sequencer wired to a behavioural 8-bit bidirectional shift
// register (load=1 loads IN; else dr=1 shifts toward MSB keeping q[0],
// dr=0 shifts toward LSB keeping q[7]).
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       dir;
   logic [2:0] amount;
   logic [7:0] operand;
   logic [7:0] sr_q;
   logic       sr_load;
   logic       sr_dr;
   logic [7:0] sr_in;
   logic       busy;
   logic       done;
   logic [7:0] result;

   int passes = 0;
   int total  = 0;
   int done_cnt = 0;
   int busy_cnt = 0;
   int noload_cnt = 0;
   int d0, b0, n0;
   logic [7:0] exp_q;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(8), .AMT_W(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .dir     (dir),
      .amount  (amount),
      .operand (operand),
      .sr_q    (sr_q),
      .sr_load (sr_load),
      .sr_dr   (sr_dr),
      .sr_in   (sr_in),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   // shift register model, shares rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sr_q <= 8'h00;
      else if (sr_load)
         sr_q <= sr_in;
      else if (sr_dr)
         sr_q <= {sr_q[6:0], sr_q[0]};
      else
         sr_q <= {sr_q[7], sr_q[7:1]};
   end

   // per-cycle event counters sampled mid-cycle
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (done === 1'b1)    done_cnt++;
         if (busy === 1'b1)    busy_cnt++;
         if (sr_load === 1'b0) noload_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [7:0] op, input logic d, input logic [2:0] amt);
      operand = op;
      dir     = d;
      amount  = amt;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dir = 1'b0; amount = 3'd0; operand = 8'h00;
      #12;
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_done",    32'(done),    32'd0);
      chk("rst_sr_load", 32'(sr_load), 32'd1);
      chk("rst_sr_dr",   32'(sr_dr),   32'd0);
      chk("rst_sr_q",    32'(sr_q),    32'h00);
      step();
      rst = 1'b0;
      step();

      // test 1: B4, left, 3
      d0 = done_cnt; b0 = busy_cnt;
      start_op(8'hB4, 1'b1, 3'd3);
      dir = 1'b0; amount = 3'd0;   // must not affect the latched request
      chk("t1_busy_load", 32'(busy), 32'd1);
      step(); chk("t1_q_load", 32'(sr_q), 32'hB4);
      chk("t1_sr_load0", 32'(sr_load), 32'd0);
      chk("t1_sr_dr",    32'(sr_dr),   32'd1);
      step(); chk("t1_q1", 32'(sr_q), 32'h68);
      step(); chk("t1_q2", 32'(sr_q), 32'hD0);
      step(); chk("t1_q3", 32'(sr_q), 32'hA0);
      chk("t1_done",   32'(done),   32'd1);
      chk("t1_result", 32'(result), 32'hA0);
      chk("t1_busy_done", 32'(busy), 32'd0);
      step(); chk("t1_done_clr", 32'(done), 32'd0);
      chk("t1_busy_cycles", 32'(busy_cnt - b0), 32'd4);
      chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

      // test 2: 96, right (arithmetic), 2
      start_op(8'h96, 1'b0, 3'd2);
      step(); chk("t2_q_load", 32'(sr_q), 32'h96);
      step(); chk("t2_q1", 32'(sr_q), 32'hCB);
      step(); chk("t2_q2", 32'(sr_q), 32'hE5);
      chk("t2_done",   32'(done),   32'd1);
      chk("t2_result", 32'(result), 32'hE5);
      step();

      // test 3: 5A, amount 0
      n0 = noload_cnt; d0 = done_cnt;
      start_op(8'h5A, 1'b1, 3'd0);
      chk("t3_no_done_in_load", 32'(done), 32'd0);
      step();
      chk("t3_done",   32'(done),   32'd1);
      chk("t3_result", 32'(result), 32'h5A);
      step();
      chk("t3_sr_load_never_0", 32'(noload_cnt - n0), 32'd0);
      chk("t3_done_pulses",     32'(done_cnt - d0),   32'd1);

      // test 4: 01, left, 7 -> fills with ones
      start_op(8'h01, 1'b1, 3'd7);
      step(); chk("t4_q_load", 32'(sr_q), 32'h01);
      exp_q = 8'h01;
      for (int i = 0; i < 7; i++) begin
         step();
         exp_q = {exp_q[6:0], 1'b1};
         chk($sformatf("t4_q%0d", i + 1), 32'(sr_q), 32'(exp_q));
      end
      chk("t4_done",   32'(done),   32'd1);
      chk("t4_result", 32'(result), 32'hFF);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("t4_hold%0d", i), 32'(sr_q), 32'hFF);
      end

      // test 5: second start mid-SHIFT is ignored
      d0 = done_cnt;
      start_op(8'hB4, 1'b1, 3'd3);
      step();
      step(); chk("t5_q1", 32'(sr_q), 32'h68);
      operand = 8'h11; dir = 1'b0; amount = 3'd1; start = 1'b1;
      step(); start = 1'b0;
      chk("t5_q2", 32'(sr_q), 32'hD0);
      step();
      chk("t5_done",   32'(done),   32'd1);
      chk("t5_result", 32'(result), 32'hA0);
      step(); step(); step();
      chk("t5_idle",        32'(busy),            32'd0);
      chk("t5_done_pulses", 32'(done_cnt - d0),   32'd1);
      chk("t5_q_held",      32'(sr_q),            32'hA0);

      // test 6: reset during SHIFT aborts, then rerun test 1
      d0 = done_cnt;
      start_op(8'hB4, 1'b1, 3'd3);
      step();
      step();
      rst = 1'b1;
      #1;
      chk("t6_busy",    32'(busy),    32'd0);
      chk("t6_done",    32'(done),    32'd0);
      chk("t6_sr_load", 32'(sr_load), 32'd1);
      chk("t6_sr_q",    32'(sr_q),    32'h00);
      step(); step();
      rst = 1'b0;
      step(); step(); step();
      chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
      start_op(8'hB4, 1'b1, 3'd3);
      step(); step(); step(); step();
      chk("t6_rerun_done",   32'(done),   32'd1);
      chk("t6_rerun_result", 32'(result), 32'hA0);
      step();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
